// File: rtl/iddmm_ctrl.sv
// Sequencer for one iddmm_cal Montgomery multiply: clears the a RAM, walks the
// N x (N+1) i/j schedule with row gaps, qualifies write strobes and reports completion.
module iddmm_ctrl #(
    parameter int K        = 128,
    parameter int N        = 32,
    parameter int ADDR_W   = $clog2(N),
    parameter int ROW_GAP  = 20,
    parameter int WR_LAT   = 19,
    parameter int SUB_LAT  = 22,
    parameter int DONE_TMO = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              res_sel,
    output logic [ADDR_W-1:0] i_cnt,
    output logic [ADDR_W:0]   j_cnt,
    output logic              iss_vld,
    output logic              a_clr_en,
    output logic [ADDR_W:0]   a_clr_addr,
    output logic              wr_qual,
    output logic              sub_qual,
    input  logic              cal_done,
    input  logic              cal_sign
);

    // One shared down-the-phase counter sized for the longest phase.
    localparam int M1    = (N + 1 > ROW_GAP) ? N + 1 : ROW_GAP;
    localparam int CMAX  = (M1 > DONE_TMO) ? M1 : DONE_TMO;
    localparam int CNT_W = $clog2(CMAX + 1);

    localparam logic [CNT_W-1:0]  CNT_N       = CNT_W'(N);
    localparam logic [CNT_W-1:0]  CNT_GAP_END = CNT_W'(ROW_GAP - 1);
    localparam logic [CNT_W-1:0]  CNT_TMO_END = CNT_W'(DONE_TMO - 2);
    localparam logic [ADDR_W-1:0] I_LAST      = ADDR_W'(N - 1);

    if (K < 1) begin : g_bad_k
        $error("iddmm_ctrl: K must be positive");
    end
    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("iddmm_ctrl: N must be a power of 2 and >= 2");
    end
    if (ROW_GAP < WR_LAT) begin : g_bad_gap
        $error("iddmm_ctrl: ROW_GAP must cover WR_LAT so a[j] lands before re-read");
    end
    if (DONE_TMO < 2) begin : g_bad_tmo
        $error("iddmm_ctrl: DONE_TMO must be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ISSUE, S_GAP, S_DRAIN, S_FIN1, S_FIN2, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic                res_sel_q, res_sel_d;
    logic [WR_LAT-1:0]   wr_sr_q, wr_sr_d;
    logic [SUB_LAT-1:0]  sub_sr_q, sub_sr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            i_q       <= '0;
            res_sel_q <= 1'b0;
            wr_sr_q   <= '0;
            sub_sr_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            i_q       <= i_d;
            res_sel_q <= res_sel_d;
            wr_sr_q   <= wr_sr_d;
            sub_sr_q  <= sub_sr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        i_d       = i_q;
        res_sel_d = res_sel_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CLEAR;
                    cnt_d     = '0;
                    i_d       = '0;
                    res_sel_d = 1'b0;
                end
            end
            S_CLEAR: begin
                if (cnt_q == CNT_N) begin
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ISSUE: begin
                if (cnt_q == CNT_N) begin
                    state_d = (i_q == I_LAST) ? S_DRAIN : S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_GAP_END) begin
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                    i_d     = i_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // cal_done wins over a timeout landing in the same cycle
                if (cal_done) begin
                    state_d = S_FIN1;
                end else if (cnt_q == CNT_TMO_END) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIN1: begin
                state_d   = S_FIN2;
                res_sel_d = cal_sign;
            end
            S_FIN2, S_ERR: state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            i_d       = '0;
            res_sel_d = res_sel_q;
        end
    end

    // Qualifier delay lines follow iss_vld only; abort drops any beats in flight.
    always_comb begin
        wr_sr_d  = abort ? '0 : WR_LAT'({wr_sr_q, iss_vld});
        sub_sr_d = abort ? '0 : SUB_LAT'({sub_sr_q, iss_vld});
    end

    always_comb begin
        busy       = (state_q != S_IDLE) && (state_q != S_FIN2) && (state_q != S_ERR);
        done       = (state_q == S_FIN2);
        err        = (state_q == S_ERR);
        iss_vld    = (state_q == S_ISSUE);
        a_clr_en   = (state_q == S_CLEAR);
        a_clr_addr = (state_q == S_CLEAR) ? cnt_q[ADDR_W:0] : '0;
        i_cnt      = i_q;
        j_cnt      = (state_q == S_ISSUE) ? cnt_q[ADDR_W:0] : '1;
        res_sel    = res_sel_q;
        wr_qual    = wr_sr_q[WR_LAT-1];
        sub_qual   = sub_sr_q[SUB_LAT-1];
    end

endmodule

// File: tb/tb_iddmm_ctrl.sv
// Bench for iddmm_ctrl: directed and randomized runs checked cycle by cycle against
// a schedule model derived from the operation's timing rules.
module tb_iddmm_ctrl;

    localparam int N        = 4;
    localparam int ADDR_W   = 2;
    localparam int ROW_GAP  = 20;
    localparam int WR_LAT   = 19;
    localparam int SUB_LAT  = 22;
    localparam int DONE_TMO = 64;

    // Schedule shape, as offsets from the cycle in which start is driven.
    localparam int ROW   = N + 1 + ROW_GAP;
    localparam int F_OFF = N + 2;
    localparam int L_OFF = F_OFF + (N - 1) * ROW + N;
    localparam int JONES = (1 << (ADDR_W + 1)) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              busy, done, err, res_sel;
    logic [ADDR_W-1:0] i_cnt;
    logic [ADDR_W:0]   j_cnt;
    logic              iss_vld, a_clr_en;
    logic [ADDR_W:0]   a_clr_addr;
    logic              wr_qual, sub_qual;
    logic              cal_done = 1'b0;
    logic              cal_sign = 1'b0;

    int checks = 0;
    int failures = 0;
    int wq_cnt, sq_cnt, done_cnt, err_cnt;

    iddmm_ctrl #(
        .K(128), .N(N), .ADDR_W(ADDR_W), .ROW_GAP(ROW_GAP),
        .WR_LAT(WR_LAT), .SUB_LAT(SUB_LAT), .DONE_TMO(DONE_TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err), .res_sel(res_sel),
        .i_cnt(i_cnt), .j_cnt(j_cnt), .iss_vld(iss_vld),
        .a_clr_en(a_clr_en), .a_clr_addr(a_clr_addr),
        .wr_qual(wr_qual), .sub_qual(sub_qual),
        .cal_done(cal_done), .cal_sign(cal_sign)
    );

    always #5 clk = ~clk;

    typedef struct {
        int busy, done, err, iss, clr, clr_addr, i, j, wq, sq, rs;
    } exp_t;

    function automatic int vld_at(int d);
        return (d >= F_OFF && d <= L_OFF && ((d - F_OFF) % ROW) <= N) ? 1 : 0;
    endfunction

    function automatic int accepted(int dc);
        return (dc >= L_OFF + 1 && dc <= L_OFF + DONE_TMO - 1) ? 1 : 0;
    endfunction

    function automatic int end_of(int dc);
        return accepted(dc) != 0 ? dc + 2 : L_OFF + DONE_TMO;
    endfunction

    function automatic exp_t model(int d, int dc, int sgn);
        exp_t e;
        int   fin;
        fin        = end_of(dc);
        e.busy     = (d >= 1 && d < fin) ? 1 : 0;
        e.done     = (accepted(dc) != 0 && d == fin) ? 1 : 0;
        e.err      = (accepted(dc) == 0 && d == fin) ? 1 : 0;
        e.clr      = (d >= 1 && d <= N + 1) ? 1 : 0;
        e.clr_addr = e.clr != 0 ? d - 1 : 0;
        e.iss      = vld_at(d);
        e.j        = e.iss != 0 ? (d - F_OFF) % ROW : JONES;
        e.i        = (d < F_OFF) ? 0 : (d <= L_OFF) ? (d - F_OFF) / ROW : N - 1;
        e.wq       = vld_at(d - WR_LAT);
        e.sq       = vld_at(d - SUB_LAT);
        e.rs       = (accepted(dc) != 0 && d >= dc + 2) ? sgn : 0;
        return e;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.busy = 0; e.done = 0; e.err = 0; e.iss = 0; e.clr = 0; e.clr_addr = 0;
        e.i = 0; e.j = JONES; e.wq = 0; e.sq = 0; e.rs = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_cycle(input exp_t e, input bit chk_i);
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("err", 32'(err), 32'(e.err));
        chk("iss_vld", 32'(iss_vld), 32'(e.iss));
        chk("a_clr_en", 32'(a_clr_en), 32'(e.clr));
        chk("a_clr_addr", 32'(a_clr_addr), 32'(e.clr_addr));
        chk("j_cnt", 32'(j_cnt), 32'(e.j));
        chk("wr_qual", 32'(wr_qual), 32'(e.wq));
        chk("sub_qual", 32'(sub_qual), 32'(e.sq));
        chk("res_sel", 32'(res_sel), 32'(e.rs));
        if (chk_i) chk("i_cnt", 32'(i_cnt), 32'(e.i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation: dc = cycle offset of cal_done (-1 none), ab = abort offset,
    // rs = reset offset (-1 = unused), noise = spurious start/cal_done during the schedule.
    task automatic run(input int dc, input int sgn, input bit noise, input int ab, input int rs);
        exp_t e;
        int   last;
        bool_block: begin end
        last = (ab >= 0) ? ab + 30 : (rs >= 0) ? rs + 30 : end_of(dc) + SUB_LAT + 3;
        wq_cnt = 0; sq_cnt = 0; done_cnt = 0; err_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int d = 1; d <= last; d++) begin
            if ((ab >= 0 && d > ab) || (rs >= 0 && d > rs)) e = idle_exp();
            else e = model(d, dc, sgn);
            check_cycle(e, ab < 0 || d <= ab);
            wq_cnt += int'(wr_qual);
            sq_cnt += int'(sub_qual);
            done_cnt += int'(done);
            err_cnt += int'(err);
            cal_done = (d == dc);
            start = 1'b0;
            abort = (d == ab);
            if (noise && d >= F_OFF && d <= L_OFF) begin
                cal_done = cal_done | ($urandom_range(0, 3) == 0);
                start = ($urandom_range(0, 3) == 0);
            end
            cal_sign = (d == dc + 1) ? 1'(sgn) : 1'($urandom_range(0, 1));
            if (rs >= 0 && d == rs) begin
                rst_n = 1'b0;
                #1;
                check_cycle(idle_exp(), 1'b1);
            end
            if (rs >= 0 && d == rs + 5) rst_n = 1'b1;
            step();
        end
        cal_done = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        if (ab < 0 && rs < 0) begin
            chk("wr_qual_total", 32'(wq_cnt), 32'(N * (N + 1)));
            chk("sub_qual_total", 32'(sq_cnt), 32'(N * (N + 1)));
            chk("done_count", 32'(done_cnt), 32'(accepted(dc)));
            chk("err_count", 32'(err_cnt), 32'(1 - accepted(dc)));
        end
    endtask

    initial begin
        int dc;
        int sg;
        // Reset state
        repeat (3) step();
        check_cycle(idle_exp(), 1'b1);
        rst_n = 1'b1;
        step();
        check_cycle(idle_exp(), 1'b1);

        // Nominal: cal_done at t105, sign 1 -> done t107
        run(105, 1, 1'b0, -1, -1);
        chk("res_sel_hold", 32'(res_sel), 32'd1);

        // Timeout: no cal_done -> err at t149
        run(-1, 0, 1'b0, -1, -1);

        // Abort at row 2 j=2, then a clean schedule
        run(-1, 0, 1'b0, F_OFF + 2 * ROW + 2, -1);
        run(105, 1, 1'b0, -1, -1);

        // Earliest and latest accepted cal_done
        run(L_OFF + 1, 0, 1'b0, -1, -1);
        run(L_OFF + DONE_TMO - 1, 1, 1'b0, -1, -1);

        // Spurious start / cal_done while busy
        run(105, 0, 1'b1, -1, -1);

        // Reset mid-operation, then a normal run
        run(-1, 0, 1'b0, -1, 40);
        run(105, 1, 1'b0, -1, -1);

        // Randomized runs
        for (int r = 0; r < 4; r++) begin
            dc = int'($urandom_range(L_OFF + 1, L_OFF + DONE_TMO - 1));
            sg = int'($urandom_range(0, 1));
            run(dc, sg, 1'($urandom_range(0, 1)), -1, -1);
            repeat ($urandom_range(0, 3)) begin
                step();
                chk("idle_busy", 32'(busy), 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
